rbs_seq_sub: RTL and testbench

Multi-cycle N-bit unsigned subtractor, Diff = A − B, with borrow-out. Computes W bits per clock using a ripple-borrow chain of full-subtractor cells. Operands are accepted and results returned through valid/ready handshakes. It is the subtract-direction companion to the team's ripple-carry adder, for datapaths that need wide subtraction without a full N-bit combinational borrow path.

---
 rtl/rbs_pkg.sv | 10 +
 rtl/fs.sv | 13 +
 rtl/rbs_seq_sub.sv | 97 +++++++++
 tb/tb_rbs_seq_sub.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rbs_pkg.sv
// Shared state encoding for the sequential ripple-borrow subtractor.
package rbs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fs.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
module fs (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/rbs_seq_sub.sv
// Multi-cycle N-bit unsigned subtractor, W bits per clock through a ripple-borrow chain.
module rbs_seq_sub
  import rbs_pkg::*;
#(
  parameter int unsigned N = 64,
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Diff,
  output logic         B_out
);

  localparam int unsigned CHUNKS = N / W;
  localparam int unsigned CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          borrow;
  logic [N-1:0]  a_sh;
  logic [N-1:0]  b_sh;

  logic [W:0]    bc;
  logic [W-1:0]  cd;
  logic [N-1:0]  diff_nxt;

  // Borrow from the previous chunk enters the bottom of the chain.
  assign bc[0] = borrow;

  for (genvar i = 0; i < W; i++) begin : g_chain
    fs u_fs (
      .a    (a_sh[i]),
      .b    (b_sh[i]),
      .bin  (bc[i]),
      .d    (cd[i]),
      .bout (bc[i+1])
    );
  end

  // Chunk result enters at the MSB end; after CHUNKS shifts chunk 0 sits at the LSBs.
  assign diff_nxt = (N'(cd) << (N - W)) | (Diff >> W);

  assign in_ready = (state == IDLE);

  // Control FSM and datapath registers with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      borrow    <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      Diff      <= '0;
      B_out     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh   <= A;
            b_sh   <= B;
            borrow <= 1'b0;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          Diff   <= diff_nxt;
          a_sh   <= a_sh >> W;
          b_sh   <= b_sh >> W;
          borrow <= bc[W];
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            B_out     <= bc[W];
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rbs_seq_sub.sv
// Directed and randomised checks of rbs_seq_sub across several N/W configurations.
module tb_rbs_seq_sub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  // Main instance: N=16, W=4
  logic        iv = 1'b0, ir, ov, ordy = 1'b1, bo;
  logic [15:0] a = '0, b = '0, d;

  // Sweep instances
  logic        iv8 = 1'b0, ir8, ov8, or8 = 1'b1, bo8;
  logic [7:0]  a8 = '0, b8 = '0, d8;
  logic        iv64 = 1'b0, ir64, ov64, or64 = 1'b1, bo64;
  logic [63:0] a64 = '0, b64 = '0, d64;
  logic        iv32 = 1'b0, ir32, ov32, or32 = 1'b1, bo32;
  logic [31:0] a32 = '0, b32 = '0, d32;

  rbs_seq_sub #(.N(16), .W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .A(a), .B(b),
    .out_valid(ov), .out_ready(ordy), .Diff(d), .B_out(bo)
  );

  rbs_seq_sub #(.N(8), .W(8)) u_s8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
    .out_valid(ov8), .out_ready(or8), .Diff(d8), .B_out(bo8)
  );

  rbs_seq_sub #(.N(64), .W(8)) u_s64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64), .A(a64), .B(b64),
    .out_valid(ov64), .out_ready(or64), .Diff(d64), .B_out(bo64)
  );

  rbs_seq_sub #(.N(32), .W(1)) u_s32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .A(a32), .B(b32),
    .out_valid(ov32), .out_ready(or32), .Diff(d32), .B_out(bo32)
  );

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Present one operand pair to the main instance and wait (bounded) for out_valid.
  task automatic run_op(input logic [15:0] x, input logic [15:0] y,
                        output logic [15:0] rd, output logic rb, output int lat);
    iv = 1'b1; a = x; b = y;
    tick();
    iv = 1'b0;
    lat = 0;
    while (!ov && lat < 40) begin
      tick();
      lat++;
    end
    rd = d;
    rb = bo;
  endtask

  task automatic test_reset();
    tick();
    n_vec++;
    if (ov !== 1'b0 || d !== 16'h0 || bo !== 1'b0 || ir !== 1'b1) begin
      $display("FAIL reset: ov=%b d=%h bo=%b ir=%b, want ov=0 d=0000 bo=0 ir=1", ov, d, bo, ir);
      n_bad++;
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [15:0] rd; logic rb; int lat;
    ordy = 1'b1;
    run_op(16'h1234, 16'h0234, rd, rb, lat);
    n_vec++;
    if (lat !== 4) begin
      $display("FAIL basic_latency: got %0d want 4", lat); n_bad++;
    end
    n_vec++;
    if (rd !== 16'h1000 || rb !== 1'b0) begin
      $display("FAIL basic_result: got %h/%b want 1000/0", rd, rb); n_bad++;
    end
    tick();
    n_vec++;
    if (ir !== 1'b1 || ov !== 1'b0) begin
      $display("FAIL basic_return_idle: ir=%b ov=%b want 1/0", ir, ov); n_bad++;
    end
  endtask

  task automatic test_borrow();
    logic [15:0] rd; logic rb; int lat;
    run_op(16'h0000, 16'h0001, rd, rb, lat);
    n_vec++;
    if (rd !== 16'hFFFF || rb !== 1'b1 || lat !== 4) begin
      $display("FAIL borrow_ripple: got %h/%b lat %0d want ffff/1 lat 4", rd, rb, lat); n_bad++;
    end
    tick();
    run_op(16'h8000, 16'h8000, rd, rb, lat);
    n_vec++;
    if (rd !== 16'h0000 || rb !== 1'b0 || lat !== 4) begin
      $display("FAIL equal_msb: got %h/%b lat %0d want 0000/0 lat 4", rd, rb, lat); n_bad++;
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [15:0] rd; logic rb; int lat;
    ordy = 1'b0;
    run_op(16'h00F0, 16'h000F, rd, rb, lat);
    n_vec++;
    if (rd !== 16'h00E1 || rb !== 1'b0 || lat !== 4) begin
      $display("FAIL bp_result: got %h/%b lat %0d want 00e1/0 lat 4", rd, rb, lat); n_bad++;
    end
    for (int i = 0; i < 3; i++) begin
      iv = 1'b1; a = 16'hFFFF; b = 16'h0000;
      tick();
      n_vec++;
      if (ov !== 1'b1 || d !== 16'h00E1 || bo !== 1'b0 || ir !== 1'b0) begin
        $display("FAIL bp_hold%0d: ov=%b d=%h bo=%b ir=%b want 1/00e1/0/0", i, ov, d, bo, ir);
        n_bad++;
      end
    end
    iv = 1'b0;
    ordy = 1'b1;
    tick();
    n_vec++;
    if (ov !== 1'b0 || ir !== 1'b1 || d !== 16'h00E1) begin
      $display("FAIL bp_release: ov=%b ir=%b d=%h want 0/1/00e1", ov, ir, d); n_bad++;
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] rd; logic rb; int lat;
    iv = 1'b1; a = 16'hABCD; b = 16'h1111;
    tick();
    iv = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (ov !== 1'b0 || d !== 16'h0 || bo !== 1'b0 || ir !== 1'b1) begin
      $display("FAIL mid_reset: ov=%b d=%h bo=%b ir=%b want 0/0000/0/1", ov, d, bo, ir);
      n_bad++;
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run_op(16'h0005, 16'h0003, rd, rb, lat);
    n_vec++;
    if (rd !== 16'h0002 || rb !== 1'b0 || lat !== 4) begin
      $display("FAIL after_reset: got %h/%b lat %0d want 0002/0 lat 4", rd, rb, lat); n_bad++;
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] pa[3], pb[3], ed[3], rd[3];
    logic        eb[3], rb[3];
    int          acc_cyc[3];
    int          na, nr;
    logic        acc;
    pa[0] = 16'h0010; pb[0] = 16'h0001; ed[0] = 16'h000F; eb[0] = 1'b0;
    pa[1] = 16'h0001; pb[1] = 16'h0010; ed[1] = 16'hFFF1; eb[1] = 1'b1;
    pa[2] = 16'hFFFF; pb[2] = 16'h0001; ed[2] = 16'hFFFE; eb[2] = 1'b0;
    na = 0; nr = 0;
    ordy = 1'b1;
    iv = 1'b1; a = pa[0]; b = pb[0];
    for (int t = 0; t < 60 && nr < 3; t++) begin
      acc = ir && iv;
      tick();
      if (acc && na < 3) begin
        acc_cyc[na] = cyc;
        na++;
        if (na < 3) begin
          a = pa[na]; b = pb[na];
        end else begin
          iv = 1'b0;
        end
      end
      if (ov && nr < 3) begin
        rd[nr] = d; rb[nr] = bo;
        nr++;
      end
    end
    iv = 1'b0;
    n_vec++;
    if (na !== 3 || nr !== 3) begin
      $display("FAIL b2b_count: accepts %0d results %0d want 3/3", na, nr); n_bad++;
    end else begin
      for (int i = 1; i < 3; i++) begin
        n_vec++;
        if (acc_cyc[i] - acc_cyc[i-1] !== 6) begin
          $display("FAIL b2b_gap%0d: got %0d want 6", i, acc_cyc[i] - acc_cyc[i-1]); n_bad++;
        end
      end
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if (rd[i] !== ed[i] || rb[i] !== eb[i]) begin
          $display("FAIL b2b_res%0d: got %h/%b want %h/%b", i, rd[i], rb[i], ed[i], eb[i]);
          n_bad++;
        end
      end
    end
    tick();
  endtask

  task automatic test_sweep_8();
    logic [7:0] x, y, e; logic eb; int lat;
    for (int i = 0; i < 200; i++) begin
      x = 8'($urandom); y = 8'($urandom);
      e = x - y; eb = (x < y);
      iv8 = 1'b1; a8 = x; b8 = y;
      tick();
      iv8 = 1'b0;
      lat = 0;
      while (!ov8 && lat < 10) begin tick(); lat++; end
      n_vec++;
      if (ov8 !== 1'b1 || d8 !== e || bo8 !== eb || lat !== 1) begin
        $display("FAIL sweep8 %h-%h: got %h/%b ov=%b lat %0d want %h/%b lat 1",
                 x, y, d8, bo8, ov8, lat, e, eb);
        n_bad++;
      end
      tick();
    end
  endtask

  task automatic test_sweep_64();
    logic [63:0] x, y, e; logic eb; int lat;
    for (int i = 0; i < 200; i++) begin
      x = {$urandom, $urandom}; y = {$urandom, $urandom};
      if (i == 0) begin x = 64'h0; y = 64'h1; end
      if (i == 1) begin x = 64'hFFFF_FFFF_FFFF_FFFF; y = 64'hFFFF_FFFF_FFFF_FFFF; end
      e = x - y; eb = (x < y);
      iv64 = 1'b1; a64 = x; b64 = y;
      tick();
      iv64 = 1'b0;
      lat = 0;
      while (!ov64 && lat < 20) begin tick(); lat++; end
      n_vec++;
      if (ov64 !== 1'b1 || d64 !== e || bo64 !== eb || lat !== 8) begin
        $display("FAIL sweep64 %h-%h: got %h/%b ov=%b lat %0d want %h/%b lat 8",
                 x, y, d64, bo64, ov64, lat, e, eb);
        n_bad++;
      end
      tick();
    end
  endtask

  task automatic test_sweep_32();
    logic [31:0] x, y, e; logic eb; int lat;
    for (int i = 0; i < 200; i++) begin
      x = $urandom; y = $urandom;
      e = x - y; eb = (x < y);
      iv32 = 1'b1; a32 = x; b32 = y;
      tick();
      iv32 = 1'b0;
      lat = 0;
      while (!ov32 && lat < 50) begin tick(); lat++; end
      n_vec++;
      if (ov32 !== 1'b1 || d32 !== e || bo32 !== eb || lat !== 32) begin
        $display("FAIL sweep32 %h-%h: got %h/%b ov=%b lat %0d want %h/%b lat 32",
                 x, y, d32, bo32, ov32, lat, e, eb);
        n_bad++;
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_sweep_8();
    test_sweep_64();
    test_sweep_32();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
